// File: rtl/stream_demux_pkg.sv
// -----------------------------------------------------------------------------
// stream_demux_pkg
// Shared constants and types for the 1-to-4 stream demultiplexer.
//   N_LANES    : number of output lanes
//   SEL_W      : width of a lane index
//   lane_idx_t : lane index type (destination select, round-robin pointer)
// -----------------------------------------------------------------------------
package stream_demux_pkg;

    localparam int N_LANES = 4;
    localparam int SEL_W   = 2;

    typedef logic [SEL_W-1:0] lane_idx_t;

endpackage : stream_demux_pkg

// File: rtl/demux_lane_slot.sv
// -----------------------------------------------------------------------------
// demux_lane_slot
// One-entry register slot for a single output lane.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, clears valid and data
//   load_i  : write data_i into the slot this cycle
//   drain_i : consumer takes the held word this cycle
//   data_i  : incoming word
//   valid_o : slot holds a word
//   data_o  : held word (keeps its last value after draining)
// Handshake: the word held in the slot is transferred to the consumer on any
// rising edge where valid_o && ready (the parent signals this as drain_i);
// load_i is only raised by the parent when the slot is empty or draining.
// -----------------------------------------------------------------------------
module demux_lane_slot #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // A load wins over a drain so a same-cycle drain+load leaves no bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : demux_lane_slot

// File: rtl/stream_demux_1_4.sv
// -----------------------------------------------------------------------------
// stream_demux_1_4
// Routes an input valid/ready stream to one of four output lanes, each backed
// by a one-entry slot. The destination is in_sel, or the internal round-robin
// pointer when rr_mode=1.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   in_valid   : upstream offers in_data
//   in_ready   : word is accepted this cycle (combinational, depends on out_ready)
//   in_data    : offered word
//   in_sel     : destination lane when rr_mode=0
//   rr_mode    : 1 = route to rr_ptr instead of in_sel
//   out_valid  : per-lane valid
//   out_ready  : per-lane consumer ready
//   out_data   : lane k word at [k*WIDTH +: WIDTH]
//   rr_ptr     : current round-robin destination
//   busy       : any lane holds a word
// Handshake: on every interface a word moves on a rising edge where valid and
// ready are both high; valid never depends on ready.
// -----------------------------------------------------------------------------
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    input  logic                 rr_mode,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [1:0]           rr_ptr,
    output logic                 busy
);

    lane_idx_t            rr_ptr_q, rr_ptr_d;
    lane_idx_t            dest;
    logic                 xfer;
    logic [N_LANES-1:0]   load;
    logic [N_LANES-1:0]   drain;

    assign dest = rr_mode ? rr_ptr_q : in_sel;

    // The destination slot can take a word if empty or emptying this cycle.
    assign in_ready = !rst && (!out_valid[dest] || out_ready[dest]);
    assign xfer     = in_valid && in_ready;

    // The pointer only advances on transfers routed by round-robin.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer && rr_mode) begin
            rr_ptr_d = rr_ptr_q + lane_idx_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        assign load[k]  = xfer && (dest == lane_idx_t'(k));
        assign drain[k] = out_valid[k] && out_ready[k];

        demux_lane_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load_i  (load[k]),
            .drain_i (drain[k]),
            .data_i  (in_data),
            .valid_o (out_valid[k]),
            .data_o  (out_data[k*WIDTH +: WIDTH])
        );
    end

    assign rr_ptr = rr_ptr_q;
    assign busy   = |out_valid;

endmodule : stream_demux_1_4

// File: tb/tb_stream_demux_1_4.sv
module tb_stream_demux_1_4;

    localparam int WIDTH = 4;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               rr_mode;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [1:0]         rr_ptr;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    stream_demux_1_4 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .rr_mode   (rr_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rr_ptr    (rr_ptr),
        .busy      (busy)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] lane_data(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] sel, input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sel   = $urandom_range(0, 3);
        in_data  = WIDTH'($urandom_range(0, 15));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        rr_mode   = 1'b0;
        out_ready = 4'b1111;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data",  32'(out_data),  32'h0);
        check("rst_rr_ptr",    32'(rr_ptr),    32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Basic send to lane 2
        offer(2'd2, 4'hA);
        #1 check("b_in_ready", 32'(in_ready), 32'h1);
        tick();
        idle();
        check("b_out_valid", 32'(out_valid), 32'h4);
        check("b_lane2",     32'(lane_data(2)), 32'hA);
        check("b_busy",      32'(busy), 32'h1);
        tick();
        check("b_drained", 32'(out_valid), 32'h0);
        check("b_keep_data", 32'(lane_data(2)), 32'hA);

        // Stalled lane 1 does not block lane 3
        out_ready = 4'b1101;
        offer(2'd1, 4'h3);
        tick();
        check("s_l1_valid", 32'(out_valid), 32'h2);
        offer(2'd1, 4'h7);
        #1 check("s_l1_blocked", 32'(in_ready), 32'h0);
        tick();
        check("s_l1_hold",   32'(lane_data(1)), 32'h3);
        check("s_l1_valid2", 32'(out_valid), 32'h2);
        offer(2'd3, 4'h9);
        #1 check("s_l3_ready", 32'(in_ready), 32'h1);
        tick();
        idle();
        check("s_l3_valid", 32'(out_valid), 32'hA);
        check("s_l3_data",  32'(lane_data(3)), 32'h9);
        tick();
        check("s_l3_drain", 32'(out_valid), 32'h2);
        out_ready = 4'b1111;
        tick();
        check("s_all_drain", 32'(out_valid), 32'h0);

        // Same-cycle drain and load on lane 0
        out_ready = 4'b1110;
        offer(2'd0, 4'h2);
        tick();
        check("p_l0_full", 32'(lane_data(0)), 32'h2);
        out_ready = 4'b1111;
        offer(2'd0, 4'h5);
        #1 check("p_in_ready", 32'(in_ready), 32'h1);
        tick();
        idle();
        check("p_l0_valid", 32'(out_valid), 32'h1);
        check("p_l0_data",  32'(lane_data(0)), 32'h5);
        tick();
        check("p_drained", 32'(out_valid), 32'h0);

        // Round-robin back-to-back 1..6
        rr_mode = 1'b1;
        #1 check("r_ptr_start", 32'(rr_ptr), 32'h0);
        for (int i = 1; i <= 6; i++) begin
            offer(2'($urandom_range(0, 3)), WIDTH'(i));
            tick();
            check($sformatf("r_valid_%0d", i), 32'(out_valid), 32'(1 << ((i - 1) % 4)));
            check($sformatf("r_data_%0d", i),  32'(lane_data((i - 1) % 4)), 32'(i));
        end
        idle();
        check("r_ptr_end", 32'(rr_ptr), 32'h2);
        tick();
        check("r_drained", 32'(out_valid), 32'h0);

        // Round-robin blocked by stalled lane 2; fill lane 2 via in_sel
        rr_mode   = 1'b0;
        out_ready = 4'b1011;
        offer(2'd2, 4'hC);
        tick();
        idle();
        check("q_ptr_hold_sel", 32'(rr_ptr), 32'h2);
        rr_mode = 1'b1;
        offer(2'd0, 4'hD);
        for (int i = 0; i < 2; i++) begin
            #1 check("q_in_ready0", 32'(in_ready), 32'h0);
            tick();
            check("q_ptr_hold", 32'(rr_ptr), 32'h2);
            check("q_l2_hold",  32'(lane_data(2)), 32'hC);
        end
        out_ready = 4'b1111;
        #1 check("q_in_ready1", 32'(in_ready), 32'h1);
        tick();
        idle();
        check("q_l2_new", 32'(lane_data(2)), 32'hD);
        check("q_valid",  32'(out_valid), 32'h4);
        check("q_ptr_adv", 32'(rr_ptr), 32'h3);
        tick();

        // Asynchronous reset mid-cycle with lanes 0 and 3 full
        rr_mode   = 1'b0;
        out_ready = 4'b0000;
        offer(2'd0, 4'h4);
        tick();
        offer(2'd3, 4'h8);
        tick();
        idle();
        check("x_pre_valid", 32'(out_valid), 32'h9);
        #3 rst = 1'b1;
        #1;
        check("x_valid",    32'(out_valid), 32'h0);
        check("x_data",     32'(out_data),  32'h0);
        check("x_ptr",      32'(rr_ptr),    32'h0);
        check("x_in_ready", 32'(in_ready),  32'h0);
        tick();
        rst = 1'b0;
        offer(2'd3, 4'h6);
        #1 check("x_post_ready", 32'(in_ready), 32'h1);
        tick();
        idle();
        check("x_post_valid", 32'(out_valid), 32'h8);
        check("x_post_data",  32'(lane_data(3)), 32'h6);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_stream_demux_1_4
